// File: rtl/interrupt_controller.sv
`timescale 1ns/1ps
// Fixed-priority interrupt sequencer: masks pending sources, requests the CPU,
// issues a one-cycle clear to the pending register and waits for handler return.
module interrupt_controller #(
    parameter logic [7:0]  MASK_RESET = 8'hFF,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Pending,
    input  logic       Int_En,
    input  logic       Mask_WE,
    input  logic [7:0] Mask_In,
    input  logic       Int_Ack,
    input  logic       Int_Done,
    output logic       Int_Req,
    output logic [2:0] Int_Vector,
    output logic [3:0] CLR,
    output logic       Busy,
    output logic [7:0] Mask_Out,
    output logic       Timeout_Flag
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CLEAR,
        ST_SERVICE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req_q, req_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] clr_q, clr_d;
    logic       busy_q, busy_d;
    logic [7:0] mask_q, mask_d;
    logic       tflag_q, tflag_d;

    logic [7:0] qual;
    logic [2:0] winner;

    assign qual = Pending & mask_q;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (qual[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        vec_d   = vec_q;
        clr_d   = clr_q;
        busy_d  = busy_q;
        tflag_d = tflag_q;
        mask_d  = Mask_WE ? Mask_In : mask_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Int_En && (qual != 8'h00)) begin
                    state_d = ST_REQ;
                    vec_d   = winner;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            ST_REQ: begin
                // An acknowledge on the expiry cycle still wins over the timeout.
                if (Int_Ack) begin
                    state_d = ST_CLEAR;
                    req_d   = 1'b0;
                    clr_d   = {1'b1, vec_q};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    tflag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SERVICE;
                clr_d   = 4'b0000;
            end
            ST_SERVICE: begin
                if (Int_Done) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            vec_q   <= 3'd0;
            clr_q   <= 4'b0000;
            busy_q  <= 1'b0;
            mask_q  <= MASK_RESET;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            mask_q  <= mask_d;
            tflag_q <= tflag_d;
        end
    end

    assign Int_Req      = req_q;
    assign Int_Vector   = vec_q;
    assign CLR          = clr_q;
    assign Busy         = busy_q;
    assign Mask_Out     = mask_q;
    assign Timeout_Flag = tflag_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences the 8-bit interrupt pending register: masks the pending sources and picks the highest-priority one.
- Raises a request/vector to the processor control unit and waits for acknowledge.
- On acknowledge, drives the register's 4-bit CLR port to clear the serviced source, then holds off new requests until the handler signals return.
- Sits between the interrupt pending register (State[7:0] -> Pending) and the CPU control FSM.

Parameters:
- MASK_RESET, 8'hFF, Mask register value after reset (all sources enabled).
- TIMEOUT, 16, Cycles in REQ without Int_Ack before the request is withdrawn; legal range 2..255.

Ports:
- CLK  in  1  System clock; all state updates on its rising edge.
- RST  in  1  Synchronous, active-high reset.
- Pending  in  8  Pending bits from the interrupt register; bit 0 is highest priority.
- Int_En  in  1  Global interrupt enable; sampled only in IDLE.
- Mask_WE  in  1  Write strobe for the mask register.
- Mask_In  in  8  New mask value; 1 means the source is enabled.
- Int_Ack  in  1  CPU accepts the current request.
- Int_Done  in  1  Handler return (RETI), single-cycle pulse.
- Int_Req  out  1  Interrupt request to the CPU.
- Int_Vector  out  3  Index of the requested source; valid while Int_Req=1 and held through SERVICE.
- CLR  out  4  Clear command to the interrupt register: CLR[3]=valid, CLR[2:0]=bit index to clear. 4'b0000 means no clear.
- Busy  out  1  High in REQ, CLEAR and SERVICE.
- Mask_Out  out  8  Current mask.
- Timeout_Flag  out  1  Sticky; set when any request times out.

Behaviour:
- Single clock CLK; reset synchronous, active-high on RST. The same reset applies mid-operation.
- All outputs are registered.
- Reset values:
  - FSM goes to IDLE.
  - Int_Req=0, Int_Vector=0, CLR=4'b0000, Busy=0.
  - Mask_Out=MASK_RESET, Timeout_Flag=0, timeout counter=0.
- Qualified pending: Q = Pending & Mask_Out.
- Winner: lowest set index of Q (fixed priority).
- Mask write: when Mask_WE=1, Mask_Out<=Mask_In on the next edge, in any state.
  - Does not affect a request already latched (REQ/CLEAR/SERVICE).
  - Takes effect at the next IDLE arbitration.
- FSM states: IDLE, REQ, CLEAR, SERVICE.
  - IDLE: if Int_En=1 and Q!=0, then next edge: state=REQ, Int_Vector<=winner, Int_Req<=1, Busy<=1, counter<=0. Otherwise remain.
  - REQ:
    - If Int_Ack=1: next edge state=CLEAR, Int_Req<=0, CLR<={1'b1,Int_Vector}.
    - Else if counter==TIMEOUT-1: next edge state=IDLE, Int_Req<=0, Busy<=0, Timeout_Flag<=1.
    - Else counter increments.
    - If Int_Ack and timeout coincide, Int_Ack wins.
    - Int_Vector is frozen in REQ even if the Pending/Mask bit drops.
  - CLEAR: lasts exactly one cycle; CLR is valid for exactly that cycle. Next edge: state=SERVICE, CLR<=0.
  - SERVICE: Busy=1, Int_Req=0. On Int_Done=1, next edge: state=IDLE, Busy<=0.
- Latency:
  - Qualified pending to Int_Req: 1 cycle.
  - Ack to CLR pulse: 1 cycle.
  - Int_Done to re-arbitration: the IDLE cycle after the return edge. Minimum one IDLE cycle between services.
- Ignored inputs:
  - Int_Ack outside REQ.
  - Int_Done outside SERVICE.
  - Int_En changes outside IDLE (no preemption, no nesting).
- Timeout does not clear the source. The bit stays pending and is re-arbitrated from IDLE, so a higher-priority source that arrived meanwhile wins.
- Timeout_Flag is cleared only by RST.

Test Plan:
- Reset, then Pending=8'b0000_0000, Int_En=1 -> Int_Req stays 0, CLR=0, Mask_Out=8'hFF, Busy=0 for 10 cycles.
- Pending=8'b1001_0100, Int_En=1 -> Int_Req=1 and Int_Vector=2 one cycle later. Int_Ack pulse -> next cycle CLR=4'b1010 for exactly 1 cycle. Int_Done -> IDLE. With Pending=8'b1001_0000, next request has Int_Vector=4.
- Mask_In=8'hFE, Mask_WE=1, Pending=8'h01 -> no request. Pending=8'h81 -> Int_Vector=7, CLR=4'b1111 on ack.
- Pending=8'h08, no Int_Ack for 16 cycles -> Int_Req drops after cycle 16, Timeout_Flag=1. Pending=8'h09 on the next IDLE -> new request with Int_Vector=0.
- Int_Ack and the timeout-expiry cycle asserted together -> CLEAR entered, CLR=valid, Timeout_Flag stays 0. Int_Done pulsed during REQ -> ignored.
- RST asserted during SERVICE and during CLEAR -> next cycle all outputs at reset values; Mask_Out reverts to 8'hFF.
